serial_word_receiver: RTL and testbench
=======================================

// Module: serial_word_receiver
// PURPOSE
//   Receiving end of the shift-right serial link: consumes the bit stream shifted out of the
//   right_carry output of a shr-capable register, LSB first, one bit per shr strobe.
//   Reassembles WIDTH-bit words and presents them on a valid/ready output with a one-word
//   holding buffer. Flags words lost to back-pressure.
// PARAMETERS
//   WIDTH       8   data word width in bits (>= 2)
//   PARITY_ODD  0   used only with PARITY_CHECK_EN: 0 = even parity, 1 = odd parity
// PORTS
//   clk         in   1                    clock, all logic on rising edge
//   rst         in   1                    synchronous, active-high reset
//   clr         in   1                    sync abort of partially received word
//   shr         in   1                    bit strobe: carry_in is sampled this cycle
//   carry_in    in   1                    serial data bit, LSB of word first
//   data_ready  in   1                    consumer accepts data_out this cycle
//   data_out    out  WIDTH                received word
//   data_valid  out  1                    data_out holds an unconsumed word
//   bit_count   out  $clog2(WIDTH+2)      bits of current word received so far
//   overflow    out  1                    sticky: a completed word was dropped
//   parity_err  out  1                    parity result for data_out (tied 0 without macro)
// BEHAVIOUR
//   - Reset: data_out=0, data_valid=0, bit_count=0, overflow=0, parity_err=0, shift reg=0.
//     Reset mid-word discards the partial word and any buffered word.
//   - Priority per cycle: rst > clr > shr.
//   - clr: bit_count<=0, shift reg<=0, overflow<=0; data_out/data_valid untouched.
//   - shr (no clr): sr <= {carry_in, sr[WIDTH-1:1]}, bit_count++.
//   - Word completes on the strobe that delivers bit index FRAME-1
//     (FRAME = WIDTH, or WIDTH+1 with parity). bit_count then wraps to 0 in the same edge.
//   - On completion, the slot is free if data_valid=0 or data_ready=1 this cycle:
//     data_out <= {carry_in, sr[WIDTH-1:1]} (parity: data bits only), data_valid<=1.
//     Else the word is dropped, overflow<=1, and data_out/data_valid are unchanged.
//   - Latency: word visible on data_out the cycle after its final strobe.
//   - Handshake: transfer when data_valid & data_ready. data_out is stable while valid.
//     Valid is deasserted after transfer unless a new word completes in the same cycle.
//     In that case valid stays 1 and data_out takes the new word (no bubble, no loss).
//   - data_ready while data_valid=0 is ignored.
//   - FSM, 2 states:
//     RECV  - collecting data bits. Exits to PAR on the WIDTH-th strobe (macro only).
//     PAR   - awaiting the parity bit. Next strobe completes the word and returns to RECV.
//     clr or rst forces RECV.
//   - Without the macro the FSM stays in RECV permanently.
// CONFIGURATION
//   PARITY_CHECK_EN defined:
//     - Frame = WIDTH data bits + 1 parity bit.
//     - parity_err <= (^data ^ parity_bit) != PARITY_ODD, loaded with data_out and
//       valid only while data_valid=1.
//     - The parity bit never enters data_out.
//   PARITY_CHECK_EN undefined:
//     - Frame = WIDTH bits.
//     - parity_err constant 0; PAR state and PARITY_ODD unused.
// TESTING (WIDTH=8, 10 ns clock)
//   1 rst 1 cycle; 8 strobes carrying 8'hA5 LSB first, data_ready=0
//     -> next cycle data_valid=1, data_out=8'hA5, bit_count=0, overflow=0.
//   2 data_ready=0; send 8'h3C then 8'hFF
//     -> data_out stays 8'h3C, overflow=1; data_ready=1 one cycle -> data_valid=0.
//   3 8'h01 buffered; final strobe of 8'h80 in same cycle as data_ready=1
//     -> data_valid stays 1, data_out=8'h80, overflow=0.
//   4 3 strobes, clr 1 cycle, then 8 strobes of 8'h5A
//     -> bit_count 3->0 on clr, data_out=8'h5A.
//   5 5 strobes then rst; then 8 strobes of 8'hC3
//     -> all outputs 0 after rst, then data_out=8'hC3.
//   6 macro on, PARITY_ODD=0: 8'hA5 + parity 0 -> parity_err=0;
//     8'hA5 + parity 1 -> parity_err=1, data_out=8'hA5 both times.

Source files
------------

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_receiver
// Description : Receiving end of a shift-right serial link. Samples carry_in
//               on every shr strobe (LSB first), reassembles WIDTH-bit words
//               and presents them through a one-word valid/ready buffer.
//               A completed word that finds the buffer occupied is dropped
//               and the sticky overflow flag is raised.
//
//               Optional feature macro: PARITY_CHECK_EN
//                 defined   : frame = WIDTH data bits + 1 parity bit,
//                             parity_err reports the check for data_out
//                             (PARITY_ODD: 0 = even, 1 = odd parity)
//                 undefined : frame = WIDTH bits, parity_err tied to 0
//
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               clr        - synchronous abort of the partially received word
//               shr        - bit strobe, carry_in sampled this cycle
//               carry_in   - serial data bit, LSB first
//               data_ready - consumer accepts data_out this cycle
//               data_out   - received word
//               data_valid - data_out holds an unconsumed word
//               bit_count  - bits of the current frame received so far
//               overflow   - sticky, a completed word was dropped
//               parity_err - parity result for data_out
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_receiver #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         shr,
    input  logic                         carry_in,
    input  logic                         data_ready,
    output logic [WIDTH-1:0]             data_out,
    output logic                         data_valid,
    output logic [$clog2(WIDTH+2)-1:0]   bit_count,
    output logic                         overflow,
    output logic                         parity_err
);

    localparam int CW = $clog2(WIDTH + 2);

`ifdef PARITY_CHECK_EN
    localparam bit c_par_en = 1'b1;
`else
    localparam bit c_par_en = 1'b0;
`endif

    localparam logic [CW-1:0] c_last_data = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_RECV = 1'b0,
        ST_PAR  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_bit_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_overflow;
    logic             r_parity_err;

    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_word;
    logic             w_last_data;
    logic             w_complete;
    logic             w_slot_free;
    logic             w_par_err;
    logic             w_unused_cfg;

    // Without the parity feature PARITY_ODD has no function.
    assign w_unused_cfg = PARITY_ODD;

    always_comb begin
        w_shift     = {carry_in, r_sr[WIDTH-1:1]};
        w_last_data = (r_bit_count == c_last_data);
        // With parity the word completes on the strobe taken in PAR; without
        // it, on the strobe that delivers the last data bit.
        w_complete  = shr && (c_par_en ? (r_state == ST_PAR) : w_last_data);
        // In PAR the shift register already holds all data bits and the
        // current carry_in is the parity bit, which never enters the word.
        w_word      = c_par_en ? r_sr : w_shift;
        w_par_err   = ((^r_sr) ^ carry_in) != PARITY_ODD;
        // The slot can take a new word if empty or being drained right now.
        w_slot_free = !r_data_valid || data_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RECV;
            r_sr         <= '0;
            r_bit_count  <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            // Consumer handshake; a word completing this same cycle below
            // overrides this and keeps valid high.
            if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end

            if (clr) begin
                r_state     <= ST_RECV;
                r_sr        <= '0;
                r_bit_count <= '0;
                r_overflow  <= 1'b0;
            end else if (shr) begin
                case (r_state)
                    ST_RECV: begin
                        r_sr <= w_shift;
                        if (w_last_data && !c_par_en) begin
                            r_bit_count <= '0;
                        end else begin
                            r_bit_count <= r_bit_count + 1'b1;
                        end
                        if (w_last_data && c_par_en) begin
                            r_state <= ST_PAR;
                        end
                    end
                    ST_PAR: begin
                        r_bit_count <= '0;
                        r_state     <= ST_RECV;
                    end
                    default: begin
                        r_bit_count <= '0;
                        r_state     <= ST_RECV;
                    end
                endcase

                if (w_complete) begin
                    if (w_slot_free) begin
                        r_data_out   <= w_word;
                        r_data_valid <= 1'b1;
                        r_parity_err <= c_par_en && w_par_err;
                    end else begin
                        r_overflow   <= 1'b1;
                    end
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign bit_count  = r_bit_count;
    assign overflow   = r_overflow;
    assign parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_receiver
// Description : Directed self-checking bench for serial_word_receiver with
//               WIDTH=8. Inputs change on the falling edge, outputs are
//               compared on the falling edge after the rising edge that
//               produced them. With PARITY_CHECK_EN defined every frame
//               carries a parity bit and the parity scenarios are run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_receiver;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 2);

`ifdef PARITY_CHECK_EN
    localparam bit c_par_en = 1'b1;
`else
    localparam bit c_par_en = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             clr;
    logic             shr;
    logic             carry_in;
    logic             data_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [CW-1:0]    bit_count;
    logic             overflow;
    logic             parity_err;

    int n_tests = 0;
    int n_fail  = 0;

    serial_word_receiver #(
        .WIDTH      (WIDTH),
        .PARITY_ODD (1'b0)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .shr        (shr),
        .carry_in   (carry_in),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .bit_count  (bit_count),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs set before the call are sampled on its rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic strobe(input logic b);
        shr      = 1'b1;
        carry_in = b;
        tick();
        shr      = 1'b0;
        carry_in = 1'b0;
    endtask

    // Full frame; data_ready is driven with rdy_last on the final strobe only.
    task automatic send_frame(input logic [WIDTH-1:0] w, input logic p, input logic rdy_last);
        for (int i = 0; i < WIDTH; i++) begin
            if (!c_par_en && i == WIDTH - 1) data_ready = rdy_last;
            strobe(w[i]);
        end
        if (c_par_en) begin
            data_ready = rdy_last;
            strobe(p);
        end
        data_ready = 1'b0;
    endtask

    // Frame with correct even parity (when parity is in use).
    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_last);
        send_frame(w, ^w, rdy_last);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; shr = 1'b0; carry_in = 1'b0; data_ready = 1'b0;
        @(negedge clk);

        // ---- 1: reset values, basic receive and latency ----
        do_reset();
        check("rst_data_out",   32'(data_out),   32'h0);
        check("rst_valid",      32'(data_valid), 32'h0);
        check("rst_bit_count",  32'(bit_count),  32'h0);
        check("rst_overflow",   32'(overflow),   32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        for (int i = 0; i < WIDTH - 1; i++) strobe(((8'hA5 >> i) & 8'h01) != 0);
        check("t1_partial_valid", 32'(data_valid), 32'h0);
        check("t1_partial_count", 32'(bit_count),  32'd7);
        strobe(1'b1);                       // bit 7 of 8'hA5
        if (c_par_en) strobe(1'b0);         // even parity of 8'hA5
        check("t1_valid",    32'(data_valid), 32'h1);
        check("t1_data",     32'(data_out),   32'hA5);
        check("t1_count",    32'(bit_count),  32'h0);
        check("t1_overflow", 32'(overflow),   32'h0);

        // ---- 2: back-pressure drops the second word ----
        do_reset();
        send_word(8'h3C, 1'b0);
        send_word(8'hFF, 1'b0);
        check("t2_data",     32'(data_out),   32'h3C);
        check("t2_valid",    32'(data_valid), 32'h1);
        check("t2_overflow", 32'(overflow),   32'h1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("t2_drained",     32'(data_valid), 32'h0);
        check("t2_ovf_sticky",  32'(overflow),   32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t2_clr_ovf",     32'(overflow),   32'h0);
        check("t2_clr_data",    32'(data_out),   32'h3C);

        // ---- 3: completion together with consumption, no bubble ----
        do_reset();
        send_word(8'h01, 1'b0);
        check("t3_first", 32'(data_out), 32'h01);
        send_word(8'h80, 1'b1);
        check("t3_valid",    32'(data_valid), 32'h1);
        check("t3_data",     32'(data_out),   32'h80);
        check("t3_overflow", 32'(overflow),   32'h0);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("t3_drained", 32'(data_valid), 32'h0);
        // data_ready while empty is ignored
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("t3_idle_ready", 32'(data_valid), 32'h0);

        // ---- 4: clr aborts a partial word ----
        strobe(1'b1); strobe(1'b1); strobe(1'b1);
        check("t4_count3", 32'(bit_count), 32'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_count0",     32'(bit_count),  32'd0);
        check("t4_clr_valid",  32'(data_valid), 32'h0);
        send_word(8'h5A, 1'b0);
        check("t4_data",  32'(data_out),   32'h5A);
        check("t4_valid", 32'(data_valid), 32'h1);

        // ---- 5: reset mid-word discards partial and buffered words ----
        for (int i = 0; i < 5; i++) strobe(1'b1);
        check("t5_count5", 32'(bit_count), 32'd5);
        do_reset();
        check("t5_rst_data",  32'(data_out),   32'h0);
        check("t5_rst_valid", 32'(data_valid), 32'h0);
        check("t5_rst_count", 32'(bit_count),  32'h0);
        check("t5_rst_ovf",   32'(overflow),   32'h0);
        send_word(8'hC3, 1'b0);
        check("t5_data",  32'(data_out),   32'hC3);
        check("t5_valid", 32'(data_valid), 32'h1);

        // ---- 6: parity ----
        do_reset();
        if (c_par_en) begin
            for (int i = 0; i < WIDTH; i++) strobe(((8'hA5 >> i) & 8'h01) != 0);
            check("t6_par_state_count", 32'(bit_count),  32'd8);
            check("t6_par_wait_valid",  32'(data_valid), 32'h0);
            strobe(1'b0);
            check("t6_good_data", 32'(data_out),   32'hA5);
            check("t6_good_perr", 32'(parity_err), 32'h0);
            send_frame(8'hA5, 1'b1, 1'b1);
            check("t6_bad_data",  32'(data_out),   32'hA5);
            check("t6_bad_perr",  32'(parity_err), 32'h1);
            check("t6_bad_valid", 32'(data_valid), 32'h1);
        end else begin
            send_word(8'hA5, 1'b0);
            check("t6_noparity_data", 32'(data_out),   32'hA5);
            check("t6_noparity_perr", 32'(parity_err), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
